// File: rtl/mem_wb_elastic.sv
// mem_wb_elastic
// --------------
// Two-entry elastic pipeline register between the MEM and WB stages of
// the pipeline. The head register drives the wb_* outputs directly. The
// skid register catches one extra result while WB is stalled. Because of
// the skid, in_ready can be a flop with no combinational path from
// wb_ready.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side. A producer holds valid and payload steady
// until it sees ready. in_ready depends only on the state and never on
// in_valid or wb_ready in the same cycle. The wb_* payload stays stable
// while wb_valid=1 and wb_ready=0.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   in_valid/ready  MEM-side handshake (in_ready is registered)
//   mem_*           incoming payload: wd, wreg, wdata, whilo, hi, lo
//   flush           synchronous discard of all held entries
//   wb_valid/ready  WB-side handshake
//   wb_*            head-entry payload (NOP whenever wb_valid=0)
//   occupancy       held entries 0..2; equal to the FSM state encoding
//   flush_cnt       saturating count of entries discarded by flush
module mem_wb_elastic #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int HILO_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [1:0]        occupancy,
  output logic [7:0]        flush_cnt
);

  // Payload packing: {wd, wreg, wdata, whilo, hi, lo}. An all-zero
  // vector is the NOP payload.
  localparam int PW = ADDR_W + 2 + 3 * DATA_W;
  localparam logic [PW-1:0] NOP = '0;

  // The state encoding equals the entry count, so occupancy is the
  // state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic [7:0]    flush_cnt_q, flush_cnt_d;

  logic              in_whilo;
  logic [DATA_W-1:0] in_hi, in_lo;
  logic [PW-1:0]     in_pl;
  logic              in_xfer, out_xfer;
  logic [8:0]        cnt_sum;

  // With the HI/LO path disabled, zeros are stored so those register
  // bits stay constant and can be optimised away.
  generate
    if (HILO_EN != 0) begin : g_hilo_in
      assign in_whilo = mem_whilo;
      assign in_hi    = mem_hi;
      assign in_lo    = mem_lo;
    end else begin : g_no_hilo_in
      assign in_whilo = 1'b0;
      assign in_hi    = '0;
      assign in_lo    = '0;
    end
  endgenerate

  assign in_pl    = {mem_wd, mem_wreg, mem_wdata, in_whilo, in_hi, in_lo};
  assign wb_valid = (state_q != EMPTY);
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = wb_valid & wb_ready;
  assign cnt_sum  = {1'b0, flush_cnt_q} + {7'd0, state_q};

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_d  = in_pl;
          state_d = FULL;
        end else if (in_xfer && out_xfer) begin
          head_d  = in_pl;
        end else if (out_xfer) begin
          head_d  = NOP;
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready_q is 0 here, so only the output side can move.
        if (out_xfer) begin
          head_d  = skid_q;
          skid_d  = NOP;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = NOP;
        skid_d  = NOP;
        state_d = EMPTY;
      end
    endcase
    // Flush overrides everything, including an input in the same cycle.
    if (flush) begin
      head_d      = NOP;
      skid_d      = NOP;
      state_d     = EMPTY;
      flush_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      head_q      <= NOP;
      skid_q      <= NOP;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  logic              head_whilo;
  logic [DATA_W-1:0] head_hi, head_lo;

  assign {wb_wd, wb_wreg, wb_wdata, head_whilo, head_hi, head_lo} = head_q;

  generate
    if (HILO_EN != 0) begin : g_hilo_out
      assign wb_whilo = head_whilo;
      assign wb_hi    = head_hi;
      assign wb_lo    = head_lo;
    end else begin : g_no_hilo_out
      assign wb_whilo = 1'b0;
      assign wb_hi    = '0;
      assign wb_lo    = '0;
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Directed testbench for mem_wb_elastic. Two instances share one set of
// inputs: dut has the HI/LO path enabled, and dut0 has it disabled.
// Inputs change on the falling edge and outputs are sampled there.
module tb_mem_wb_elastic;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready, d0_in_ready;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        flush;
  logic        wb_valid, d0_wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_wd, d0_wb_wd;
  logic        wb_wreg, d0_wb_wreg;
  logic [31:0] wb_wdata, d0_wb_wdata;
  logic        wb_whilo, d0_wb_whilo;
  logic [31:0] wb_hi, d0_wb_hi, wb_lo, d0_wb_lo;
  logic [1:0]  occupancy, d0_occupancy;
  logic [7:0]  flush_cnt, d0_flush_cnt;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  mem_wb_elastic #(.DATA_W(32), .ADDR_W(5), .HILO_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  mem_wb_elastic #(.DATA_W(32), .ADDR_W(5), .HILO_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .flush(flush), .wb_valid(d0_wb_valid), .wb_ready(wb_ready),
    .wb_wd(d0_wb_wd), .wb_wreg(d0_wb_wreg), .wb_wdata(d0_wb_wdata),
    .wb_whilo(d0_wb_whilo), .wb_hi(d0_wb_hi), .wb_lo(d0_wb_lo),
    .occupancy(d0_occupancy), .flush_cnt(d0_flush_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic drive_idle();
    in_valid  = 1'b0;
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    mem_whilo = 1'b0;
    mem_hi    = 32'd0;
    mem_lo    = 32'd0;
    flush     = 1'b0;
  endtask

  task automatic drive_in(input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo,
                          input logic [31:0] hi, input logic [31:0] lo);
    in_valid  = 1'b1;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_whilo = whilo;
    mem_hi    = hi;
    mem_lo    = lo;
    flush     = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b0;
    wb_ready = 1'b1;
    drive_in(5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'h2);
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid);
    end
    vectors++;
    if (occupancy !== 2'd0) begin
      miscompares++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (flush_cnt !== 8'd0) begin
      miscompares++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt);
    end
    vectors++;
    if (wb_wdata !== 32'd0 || wb_wd !== 5'd0) begin
      miscompares++; $display("FAIL reset_payload: got wd=%0d wdata=%h want 0/0", wb_wd, wb_wdata);
    end
    drive_idle();
    rst = 1'b1;
  endtask

  task automatic test_single_pass();
    @(negedge clk);
    wb_ready = 1'b1;
    drive_in(5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_wd !== 5'd3 || wb_wreg !== 1'b1 || wb_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL single_head: got v=%b wd=%0d wreg=%b wdata=%h want 1/3/1/12345678",
               wb_valid, wb_wd, wb_wreg, wb_wdata);
    end
    drive_idle();
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || wb_wd !== 5'd0 || wb_wreg !== 1'b0 || wb_wdata !== 32'd0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL single_nop: got v=%b wd=%0d wreg=%b wdata=%h occ=%0d want 0/0/0/0/0",
               wb_valid, wb_wd, wb_wreg, wb_wdata, occupancy);
    end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive_in(5'd1, 1'b1, 32'hA, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || wb_wdata !== 32'hA) begin
      miscompares++;
      $display("FAIL bp_one: got occ=%0d rdy=%b wdata=%h want 1/1/a", occupancy, in_ready, wb_wdata);
    end
    drive_in(5'd2, 1'b1, 32'hB, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || wb_wdata !== 32'hA) begin
      miscompares++;
      $display("FAIL bp_full: got occ=%0d rdy=%b wdata=%h want 2/0/a", occupancy, in_ready, wb_wdata);
    end
    drive_in(5'd4, 1'b1, 32'hC, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd2 || wb_wdata !== 32'hA || wb_wd !== 5'd1) begin
      miscompares++;
      $display("FAIL bp_hold: got occ=%0d wd=%0d wdata=%h want 2/1/a", occupancy, wb_wd, wb_wdata);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || wb_wdata !== 32'hB || wb_wd !== 5'd2) begin
      miscompares++;
      $display("FAIL bp_second: got occ=%0d rdy=%b wd=%0d wdata=%h want 1/1/2/b",
               occupancy, in_ready, wb_wd, wb_wdata);
    end
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_wdata !== 32'hC || wb_wd !== 5'd4) begin
      miscompares++;
      $display("FAIL bp_third: got v=%b wd=%0d wdata=%h want 1/4/c", wb_valid, wb_wd, wb_wdata);
    end
    drive_idle();
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL bp_drain: got v=%b occ=%0d want 0/0", wb_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_v;
    wb_ready = 1'b1;
    exp_q.delete();
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i > 1) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (wb_valid !== 1'b1 || occupancy !== 2'd1 || wb_wdata !== exp_v) begin
          miscompares++;
          $display("FAIL stream_%0d: got v=%b occ=%0d wdata=%h want 1/1/%h",
                   i - 1, wb_valid, occupancy, wb_wdata, exp_v);
        end
      end
      if (i <= 8) begin
        drive_in(5'd5, 1'b1, 32'(i), 1'b0, 32'd0, 32'd0);
        exp_q.push_back(32'(i));
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_end: got v=%b left=%0d want 0/0", wb_valid, exp_q.size());
    end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    drive_in(5'd1, 1'b1, 32'h11, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive_in(5'd1, 1'b1, 32'h22, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd2) begin
      miscompares++; $display("FAIL flush_fill: got occ=%0d want 2", occupancy);
    end
    drive_in(5'd9, 1'b1, 32'hEE, 1'b0, 32'd0, 32'd0);
    flush = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0 || flush_cnt !== 8'd2 || wb_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_full: got occ=%0d v=%b cnt=%0d wdata=%h want 0/0/2/0",
               occupancy, wb_valid, flush_cnt, wb_wdata);
    end
    drive_idle();
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || wb_wdata !== 32'd0) begin
      miscompares++; $display("FAIL flush_drop: got v=%b wdata=%h want 0/0", wb_valid, wb_wdata);
    end
    wb_ready = 1'b0;
    drive_in(5'd1, 1'b1, 32'h33, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive_idle();
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (flush_cnt !== 8'd3 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL flush_one: got cnt=%0d occ=%0d want 3/0", flush_cnt, occupancy);
    end
    flush = 1'b0;
  endtask

  // Each round discards two entries: 3 + 2*125 = 253, then 255 exactly,
  // then the count must stay pinned at 255.
  task automatic test_flush_saturate();
    wb_ready = 1'b0;
    for (int r = 0; r < 127; r++) begin
      @(negedge clk);
      drive_in(5'd1, 1'b1, 32'(r), 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      drive_in(5'd1, 1'b1, 32'(r + 1000), 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      drive_idle();
      flush = 1'b1;
      if (r == 124) begin
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (flush_cnt !== 8'd253) begin
          miscompares++; $display("FAIL flush_cnt_253: got %0d want 253", flush_cnt);
        end
      end
      if (r == 125) begin
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (flush_cnt !== 8'd255) begin
          miscompares++; $display("FAIL flush_cnt_255: got %0d want 255", flush_cnt);
        end
      end
    end
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (flush_cnt !== 8'd255) begin
      miscompares++; $display("FAIL flush_cnt_sat: got %0d want 255", flush_cnt);
    end
  endtask

  task automatic test_hilo();
    wb_ready = 1'b1;
    @(negedge clk);
    drive_in(5'd6, 1'b1, 32'h55, 1'b1, 32'hFFFF_0000, 32'h0000_BEEF);
    @(negedge clk);
    vectors++;
    if (wb_whilo !== 1'b1 || wb_hi !== 32'hFFFF_0000 || wb_lo !== 32'h0000_BEEF) begin
      miscompares++;
      $display("FAIL hilo_en1: got whilo=%b hi=%h lo=%h want 1/ffff0000/0000beef", wb_whilo, wb_hi, wb_lo);
    end
    vectors++;
    if (d0_wb_whilo !== 1'b0 || d0_wb_hi !== 32'd0 || d0_wb_lo !== 32'd0 || d0_wb_wdata !== 32'h55) begin
      miscompares++;
      $display("FAIL hilo_en0: got whilo=%b hi=%h lo=%h wdata=%h want 0/0/0/55",
               d0_wb_whilo, d0_wb_hi, d0_wb_lo, d0_wb_wdata);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive_in(5'd1, 1'b1, 32'h1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive_in(5'd2, 1'b1, 32'h2, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive_idle();
    vectors++;
    if (occupancy !== 2'd2) begin
      miscompares++; $display("FAIL arst_fill: got occ=%0d want 2", occupancy);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        flush_cnt !== 8'd0 || wb_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL arst_now: got v=%b occ=%0d rdy=%b cnt=%0d wdata=%h want 0/0/1/0/0",
               wb_valid, occupancy, in_ready, flush_cnt, wb_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    drive_in(5'd8, 1'b1, 32'h77, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h77) begin
      miscompares++; $display("FAIL arst_first_xfer: got v=%b wdata=%h want 1/77", wb_valid, wb_wdata);
    end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_stream();
    test_flush();
    test_flush_saturate();
    test_hilo();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
